// File: rtl/student_circuit_gen_if.sv
// Bus between the input driver and the output display for student_circuit_gen.
// The master drives the control and data inputs. The slave returns the registered results.
interface student_circuit_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] cct_input;
    logic [WIDTH-1:0] cct_output;
    logic             ovf;

    modport master (
        output en,
        output mode,
        output cct_input,
        input  cct_output,
        input  ovf
    );

    modport slave (
        input  en,
        input  mode,
        input  cct_input,
        output cct_output,
        output ovf
    );
endinterface

// File: rtl/student_circuit_gen.sv
// Mode-selectable registered datapath with four modes: register, delay line, accumulator and running maximum.
// Changing the mode flushes all state. The new mode's behaviour starts on the following edge.
module student_circuit_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    student_circuit_gen_if.slave  bus
);

    localparam logic [1:0] MODE_REG   = 2'd0;
    localparam logic [1:0] MODE_DELAY = 2'd1;
    localparam logic [1:0] MODE_ACC   = 2'd2;
    localparam logic [1:0] MODE_MAX   = 2'd3;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] stage_q [0:DEPTH-2];
    logic [WIDTH-1:0] stage_d [0:DEPTH-2];
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_s;

    assign sum_s = {1'b0, out_q} + {1'b0, bus.cct_input};

    // Next-state selection: mode flush, then hold or per-mode update.
    always_comb begin
        out_d   = out_q;
        stage_d = stage_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        if (bus.mode != mode_q) begin
            mode_d = bus.mode;
            out_d  = {WIDTH{1'b0}};
            ovf_d  = 1'b0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                stage_d[k] = {WIDTH{1'b0}};
            end
        end else if (bus.en) begin
            case (mode_q)
                MODE_REG: begin
                    out_d = bus.cct_input;
                end
                MODE_DELAY: begin
                    stage_d[0] = bus.cct_input;
                    for (int k = 1; k < DEPTH - 1; k++) begin
                        stage_d[k] = stage_q[k-1];
                    end
                    out_d = stage_q[DEPTH-2];
                end
                MODE_ACC: begin
                    out_d = sum_s[WIDTH-1:0];
                    if (sum_s[WIDTH]) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end
                MODE_MAX: begin
                    if (bus.cct_input > out_q) begin
                        out_d = bus.cct_input;
                    end else begin
                        out_d = out_q;
                    end
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // State registers with synchronous clear, which takes priority over everything else.
    always_ff @(posedge clk) begin
        if (clear) begin
            out_q  <= {WIDTH{1'b0}};
            mode_q <= MODE_REG;
            ovf_q  <= 1'b0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                stage_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            out_q   <= out_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            stage_q <= stage_d;
        end
    end

    assign bus.cct_output = out_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_student_circuit_gen.sv
// Directed testbench for student_circuit_gen with WIDTH=8 and DEPTH=4.
// Expected values are worked out by hand.
module tb_student_circuit_gen;

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    student_circuit_gen_if #(.WIDTH(8)) bus ();

    student_circuit_gen #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic c, input logic e, input logic [1:0] m, input logic [7:0] d);
        clear         = c;
        bus.en        = e;
        bus.mode      = m;
        bus.cct_input = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_out, input logic exp_ovf);
        checks++;
        assert (bus.cct_output === exp_out)
            else begin
                errors++;
                $error("FAIL %s cct_output got %h want %h", tag, bus.cct_output, exp_out);
            end
        checks++;
        assert (bus.ovf === exp_ovf)
            else begin
                errors++;
                $error("FAIL %s ovf got %b want %b", tag, bus.ovf, exp_ovf);
            end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b1; bus.en = 1'b1; bus.mode = 2'd2; bus.cct_input = 8'hFF;

        // Reset, then REG mode.
        step(1'b1, 1'b1, 2'd2, 8'hFF);
        step(1'b1, 1'b1, 2'd2, 8'hFF); chk("reset", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd0, 8'h5A); chk("reg_5a", 8'h5A, 1'b0);
        step(1'b0, 1'b1, 2'd0, 8'hA5); chk("reg_a5", 8'hA5, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h33); chk("reg_hold", 8'hA5, 1'b0);

        // DELAY mode, including a two-cycle stall.
        step(1'b0, 1'b1, 2'd1, 8'h77); chk("dly_switch", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h11); chk("dly_e1", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h22); chk("dly_e2", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h33); chk("dly_e3", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h44); chk("dly_e4", 8'h11, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h55); chk("dly_e5", 8'h22, 1'b0);
        step(1'b0, 1'b0, 2'd1, 8'hEE); chk("dly_stall1", 8'h22, 1'b0);
        step(1'b0, 1'b0, 2'd1, 8'hEE); chk("dly_stall2", 8'h22, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h66); chk("dly_e6", 8'h33, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h77); chk("dly_e7", 8'h44, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h88); chk("dly_e8", 8'h55, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h99); chk("dly_e9", 8'h66, 1'b0);

        // ACC mode, including a wrap and a sticky overflow.
        step(1'b0, 1'b1, 2'd2, 8'h80); chk("acc_switch", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h80); chk("acc_80", 8'h80, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h7F); chk("acc_ff", 8'hFF, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h02); chk("acc_wrap", 8'h01, 1'b1);
        step(1'b0, 1'b1, 2'd2, 8'h01); chk("acc_sticky", 8'h02, 1'b1);
        step(1'b0, 1'b0, 2'd2, 8'h40); chk("acc_hold", 8'h02, 1'b1);

        // A mode change clears the accumulator and the overflow flag. MAX mode follows.
        step(1'b0, 1'b1, 2'd3, 8'hFF); chk("max_switch", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h03); chk("max_03", 8'h03, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h10); chk("max_10", 8'h10, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h05); chk("max_05", 8'h10, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'hC0); chk("max_c0", 8'hC0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'hC0); chk("max_eq", 8'hC0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h7F); chk("max_7f", 8'hC0, 1'b0);

        // Reset in the middle of a DELAY sequence discards all in-flight data.
        step(1'b0, 1'b1, 2'd1, 8'h00); chk("rst_switch", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hA1);
        step(1'b0, 1'b1, 2'd1, 8'hA2);
        step(1'b0, 1'b1, 2'd1, 8'hA3); chk("rst_inflight", 8'h00, 1'b0);
        step(1'b1, 1'b1, 2'd1, 8'hA4); chk("rst_clear", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB1); chk("rst_modechg", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB2); chk("rst_e1", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB3); chk("rst_e2", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB4); chk("rst_e3", 8'h00, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB5); chk("rst_e4", 8'hB2, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB6); chk("rst_e5", 8'hB3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
